// File: rtl/spi_pkg.sv
// Shared SPI definitions for the LCD link: word width, bus mode and the
// responder FSM state encoding. Used by both ends of the link.
package spi_pkg;

    // Bits per word on the LCD serial link.
    localparam int SPI_WIDTH = 7;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Responder FSM states.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/spi_lcd_slave_if.sv
// Serial pin bundle of the LCD SPI link. The master modport drives the
// clock, select and data-out; the slave modport drives MISO and the pad
// output enable.
interface spi_lcd_slave_if;

    logic SCLK;
    logic SS;
    logic MOSI;
    logic MISO;
    logic miso_oe;

    modport master (output SCLK, output SS, output MOSI, input MISO, input miso_oe);
    modport slave  (input SCLK, input SS, input MOSI, output MISO, output miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus a previous-value flop for an asynchronous
// control pin. Provides the synchronized level and one-cycle rise/fall
// strobes in the clk domain.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain; s3 holds the previous synchronized value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
            s3 <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its
            // predecessor; blocking here would collapse the chain into one flop.
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_lcd_slave.sv
// Mode-0 SPI responder terminating the LCD serial link. Oversamples the
// pins in the clk domain, delivers received words as rx_data/rx_valid and
// shifts a single-entry buffered transmit word back on MISO.
// Build option: define SPI_LCD_SLAVE_LSB_FIRST_EN for LSB-first shifting
// in both directions (default MSB first).
module spi_lcd_slave
    import spi_pkg::*;
#(
    parameter int               WIDTH   = SPI_WIDTH,
    parameter logic [WIDTH-1:0] TX_IDLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_lcd_slave_if.slave   spi,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             sclk_level, sclk_rise, sclk_fall;
    logic             ss_level, ss_rise, ss_fall;
    logic             mosi_s1, mosi_s;
    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] rx_sr;     // bits received so far in this word
    logic [WIDTH-2:0] tx_sr;     // bits still to send after the one on MISO
    logic [WIDTH-1:0] tx_buf;
    logic             tx_full;
    logic             miso_q;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_word;
    logic             consume;

    spi_sync_edge #(.RESET_VAL(SPI_CPOL)) u_sclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi.SCLK),
        .level    (sclk_level),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi.SS),
        .level    (ss_level),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    // SCLK timing is carried entirely by its edge strobes; the level is unused.
    logic unused_sclk;
    assign unused_sclk = sclk_level;

    // Plain 2-flop synchronizer for MOSI, aligned with the SCLK edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_s1 <= 1'b0;
            mosi_s  <= 1'b0;
        end else begin
            mosi_s1 <= spi.MOSI;
            mosi_s  <= mosi_s1;
        end
    end

    // Next rx word and the word to load into the transmitter.
    always_comb begin
`ifdef SPI_LCD_SLAVE_LSB_FIRST_EN
        rx_next = {mosi_s, rx_sr};
`else
        rx_next = {rx_sr, mosi_s};
`endif
        tx_word = tx_full ? tx_buf : TX_IDLE;
        consume = ((state == ST_IDLE) && ss_fall) ||
                  ((state == ST_SHIFT) && sclk_fall && (cnt == '0) && !ss_rise);
    end

    // Transmit buffer: a load into an empty buffer wins over a same-cycle consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so nothing reads X after reset
            // even though tx_full alone guards the buffer contents.
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (tx_load && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
        end else if (consume) begin
            tx_full <= 1'b0;
        end
    end

    // Responder FSM: bit counting, rx shifting, tx shifting and word delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            miso_q   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
`ifdef SPI_LCD_SLAVE_LSB_FIRST_EN
                        miso_q <= tx_word[0];
                        tx_sr  <= tx_word[WIDTH-1:1];
`else
                        miso_q <= tx_word[WIDTH-1];
                        tx_sr  <= tx_word[WIDTH-2:0];
`endif
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
`ifdef SPI_LCD_SLAVE_LSB_FIRST_EN
                        rx_sr <= rx_next[WIDTH-1:1];
`else
                        rx_sr <= rx_next[WIDTH-2:0];
`endif
                        if (cnt == CW'(WIDTH - 1)) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        // A fall at count 0 is a word boundary: start the next word.
`ifdef SPI_LCD_SLAVE_LSB_FIRST_EN
                        if (cnt != '0) begin
                            miso_q <= tx_sr[0];
                            tx_sr  <= tx_sr >> 1;
                        end else begin
                            miso_q <= tx_word[0];
                            tx_sr  <= tx_word[WIDTH-1:1];
                        end
`else
                        if (cnt != '0) begin
                            miso_q <= tx_sr[WIDTH-2];
                            tx_sr  <= tx_sr << 1;
                        end else begin
                            miso_q <= tx_word[WIDTH-1];
                            tx_sr  <= tx_word[WIDTH-2:0];
                        end
`endif
                    end
                    // Deselect last, so a word completing in this cycle is kept.
                    if (ss_rise) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        miso_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign spi.MISO    = miso_q;
    assign spi.miso_oe = ~ss_level;
    assign tx_ready    = ~tx_full;
    assign busy        = (state == ST_SHIFT) && (cnt != '0);

endmodule
